// File: rtl/pipe_stage_skid.sv
// Pipeline-boundary register with valid/ready handshake, flush, and an optional two-entry skid buffer.
// The control bundle reads CTRL_BUBBLE whenever the stage holds no entry, so an empty stage is always a no-op.
module pipe_stage_skid #(
  parameter int                 DATA_W      = 32,
  parameter int                 CTRL_W      = 11,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
  parameter int                 SKID_EN     = 1,
  parameter int                 CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  // State encoding equals the number of held entries, so occupancy is the state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  localparam entry_t          BUBBLE_ENTRY = entry_t'({{DATA_W{1'b0}}, CTRL_BUBBLE});
  localparam entry_t          ZERO_ENTRY   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;

  logic push;
  logic pop;

  assign in_entry  = '{data: in_data, ctrl: in_ctrl};
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q.data;
  assign out_ctrl  = main_q.ctrl;
  assign occupancy = state_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // NOTE: every signal written here gets a default first, otherwise an unassigned path infers a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_ENTRY;
      skid_d  = ZERO_ENTRY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_entry;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_entry;
          end else if (push && (SKID_EN != 0)) begin
            state_d = TWO;
            skid_d  = in_entry;
          end else if (pop) begin
            state_d = EMPTY;
            main_d  = BUBBLE_ENTRY;
          end
        end
        TWO: begin
          // The skid entry was accepted after main, so it can only move up once main leaves.
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = ZERO_ENTRY;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE_ENTRY;
          skid_d  = ZERO_ENTRY;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_ENTRY;
      skid_q  <= ZERO_ENTRY;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Counts stalled edges independently of flush; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_ONE;
    end
  end

  generate
    if (SKID_EN != 0) begin : g_skid
      // Registered ready breaks the out_ready -> in_ready path; the skid slot absorbs the in-flight entry.
      logic ready_q;

      always_ff @(posedge clock) begin
        if (reset) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_d != TWO);
        end
      end

      assign in_ready = ready_q;
    end else begin : g_noskid
      assign in_ready = !out_valid | out_ready;
    end
  endgenerate

endmodule
